// File: rtl/uart_sram_loader_if.sv
// Bus bundle between the UART boot loader, the UART receiver and the SRAM write port.
// The master modport is the loader side; the slave modport is the receiver/SRAM side.
interface uart_sram_loader_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  rx_ack;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_wstrb;
    logic                  core_hold;
    logic                  done;
    logic                  err;

    modport master (
        input  rx_data, rx_ready, mem_ready,
        output rx_ack, mem_valid, mem_addr, mem_wdata, mem_wstrb, core_hold, done, err
    );

    modport slave (
        output rx_data, rx_ready, mem_ready,
        input  rx_ack, mem_valid, mem_addr, mem_wdata, mem_wstrb, core_hold, done, err
    );
endinterface

// File: rtl/uart_sram_loader.sv
// UART boot loader: parses SYNC/ADDR/LEN/DATA frames and writes 32-bit words to SRAM.
// Define UART_LOADER_CSUM_EN to expect a trailing XOR checksum byte and drive err.
module uart_sram_loader #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         ADDR_WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    uart_sram_loader_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        DATA,
        WRITE,
        FIN
`ifdef UART_LOADER_CSUM_EN
        , CSUM
`endif
    } state_t;

    state_t                state;
    logic [1:0]            holdoff;
    logic                  byte_vld;
    logic [7:0]            rx_byte;
    logic [1:0]            idx;
    logic [31:0]           word;
    logic [15:0]           cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  take;
    logic [31:0]           word_next;
    logic [15:0]           cnt_next;

    // rx_ready lags the receiver by one clock, so it is ignored during the ack cycle and the one after.
    always_comb begin
        take = 1'b0;
        if (bus.rx_ready && holdoff == 2'd0) begin
            case (state)
                IDLE, ADDR, LEN, DATA: take = 1'b1;
`ifdef UART_LOADER_CSUM_EN
                CSUM:                  take = 1'b1;
`endif
                default:               take = 1'b0;
            endcase
        end
    end

    assign word_next = {rx_byte, word[31:8]};
    assign cnt_next  = {rx_byte, cnt[15:8]};

`ifdef UART_LOADER_CSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= 8'h00;
        end else if (byte_vld) begin
            if (state == IDLE)
                csum <= 8'h00;
            else if (state == ADDR || state == LEN || state == DATA)
                csum <= csum ^ rx_byte;
        end
    end
`else
    assign bus.err = 1'b0;
`endif

    // Bytes are latched on the take edge and interpreted one clock later, when byte_vld is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            holdoff       <= 2'd0;
            byte_vld      <= 1'b0;
            rx_byte       <= 8'h00;
            idx           <= 2'd0;
            word          <= 32'h0;
            cnt           <= 16'h0;
            addr          <= '0;
            bus.rx_ack    <= 1'b0;
            bus.mem_valid <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= 32'h0;
            bus.mem_wstrb <= 4'h0;
            bus.core_hold <= 1'b0;
            bus.done      <= 1'b0;
`ifdef UART_LOADER_CSUM_EN
            bus.err       <= 1'b0;
`endif
        end else begin
            bus.rx_ack <= take;
            byte_vld   <= take;
            bus.done   <= 1'b0;
`ifdef UART_LOADER_CSUM_EN
            bus.err    <= 1'b0;
`endif
            if (take) begin
                rx_byte <= bus.rx_data;
                holdoff <= 2'd2;
            end else if (holdoff != 2'd0) begin
                holdoff <= holdoff - 2'd1;
            end

            case (state)
                IDLE: begin
                    if (byte_vld && rx_byte == SYNC_BYTE) begin
                        state         <= ADDR;
                        bus.core_hold <= 1'b1;
                        idx           <= 2'd0;
                    end
                end
                ADDR: begin
                    if (byte_vld) begin
                        word <= word_next;
                        idx  <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            addr  <= word_next[ADDR_WIDTH-1:0];
                            idx   <= 2'd0;
                            state <= LEN;
                        end
                    end
                end
                LEN: begin
                    if (byte_vld) begin
                        cnt <= cnt_next;
                        idx <= idx + 2'd1;
                        if (idx == 2'd1) begin
                            idx <= 2'd0;
                            if (cnt_next != 16'd0) begin
                                state <= DATA;
                            end else begin
`ifdef UART_LOADER_CSUM_EN
                                state         <= CSUM;
`else
                                state         <= FIN;
                                bus.core_hold <= 1'b0;
                                bus.done      <= 1'b1;
`endif
                            end
                        end
                    end
                end
                DATA: begin
                    if (byte_vld) begin
                        word <= word_next;
                        idx  <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            idx           <= 2'd0;
                            state         <= WRITE;
                            bus.mem_valid <= 1'b1;
                            bus.mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                            bus.mem_wdata <= word_next;
                            bus.mem_wstrb <= 4'hF;
                        end
                    end
                end
                WRITE: begin
                    if (bus.mem_ready) begin
                        bus.mem_valid <= 1'b0;
                        bus.mem_wstrb <= 4'h0;
                        addr          <= addr + ADDR_WIDTH'(4);
                        cnt           <= cnt - 16'd1;
                        if (cnt != 16'd1) begin
                            state <= DATA;
                        end else begin
`ifdef UART_LOADER_CSUM_EN
                            state         <= CSUM;
`else
                            state         <= FIN;
                            bus.core_hold <= 1'b0;
                            bus.done      <= 1'b1;
`endif
                        end
                    end
                end
`ifdef UART_LOADER_CSUM_EN
                CSUM: begin
                    if (byte_vld) begin
                        state         <= FIN;
                        bus.core_hold <= 1'b0;
                        if (rx_byte == csum)
                            bus.done <= 1'b1;
                        else
                            bus.err  <= 1'b1;
                    end
                end
`endif
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_sram_loader.sv
// Self-checking bench for uart_sram_loader: frame table with a write scoreboard,
// a lagging-ready UART model, a stalling SRAM model and a mid-frame reset sequence.
module tb_uart_sram_loader;
    localparam int AW = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_sram_loader_if #(.ADDR_WIDTH(AW)) bus ();

    uart_sram_loader #(.SYNC_BYTE(8'hA5), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          prefix;
        logic [31:0] addr;
        int          nwords;
        logic [31:0] w [4];
        int          delay;
        bit          bad_csum;
        int          exp_done;
        int          exp_err;
    } frame_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    frame_t     tbl [8];
    wr_t        sb [$];
    logic [7:0] uq [$];
    logic [7:0] pre_bytes [3];

    int checks = 0, passes = 0;
    int cyc = 0, last_ack_cyc = -100, last_hs_cyc = -100;
    int acks_test = 0, done_cnt = 0, err_cnt = 0, hold_rise_ack = -1, hold_cycles = 0, writes = 0;
    int ack_viol = 0, write_ack_viol = 0, hold_viol = 0, pulse_viol = 0;
    int cfg_delay = 0, cur_delay = 0, wait_cnt = 0;
    bit rx_nonempty = 0, prev_ack = 0, prev_valid = 0, prev_hs = 0, prev_done = 0, prev_err = 0, prev_hold = 0;
    logic [31:0] prev_addr = 0, prev_wdata = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int pick_delay();
        if (cfg_delay < 0) return int'($urandom_range(3, 0));
        return cfg_delay;
    endfunction

    function automatic frame_t mk(input int prefix, input logic [31:0] addr, input int n,
                                  input logic [31:0] w0, input logic [31:0] w1,
                                  input logic [31:0] w2, input logic [31:0] w3,
                                  input int delay, input bit bad);
        frame_t f;
        f.prefix   = prefix;
        f.addr     = addr;
        f.nwords   = n;
        f.w        = '{w0, w1, w2, w3};
        f.delay    = delay;
        f.bad_csum = bad;
`ifdef UART_LOADER_CSUM_EN
        f.exp_done = bad ? 0 : 1;
        f.exp_err  = bad ? 1 : 0;
`else
        f.exp_done = 1;
        f.exp_err  = 0;
`endif
        return f;
    endfunction

    // UART receiver, SRAM and protocol monitor, all evaluated mid-cycle.
    always @(negedge clk) begin
        int r;
        wr_t w;
        cyc++;
        if (reset) begin
            uq.delete();
            rx_nonempty   = 1'b0;
            bus.rx_ready  = 1'b0;
            bus.rx_data   = 8'h00;
            bus.mem_ready = 1'b0;
            wait_cnt      = 0;
            prev_ack = 0; prev_valid = 0; prev_hs = 0; prev_done = 0; prev_err = 0; prev_hold = 0;
        end else begin
            r = (last_ack_cyc > last_hs_cyc) ? last_ack_cyc : last_hs_cyc;
            if (bus.done) begin
                done_cnt++;
                if (prev_done) pulse_viol++;
                chk("done_latency", 64'(cyc - r), 64'd1);
            end
            if (bus.err) begin
                err_cnt++;
                if (prev_err) pulse_viol++;
                chk("err_latency", 64'(cyc - r), 64'd1);
            end
            if (bus.mem_valid && !prev_valid && !prev_hs)
                chk("wr_latency", 64'(cyc - last_ack_cyc), 64'd1);
            if (bus.mem_valid && prev_valid && !prev_hs &&
                (bus.mem_addr !== prev_addr || bus.mem_wdata !== prev_wdata)) hold_viol++;
            if (bus.mem_valid && prev_hs) hold_viol++;
            if (!bus.mem_valid && bus.mem_wstrb !== 4'h0) hold_viol++;

            if (bus.rx_ack) begin
                if (prev_ack) ack_viol++;
                if (cyc - last_ack_cyc < 3) ack_viol++;
                if (bus.mem_valid) write_ack_viol++;
                last_ack_cyc = cyc;
                acks_test++;
                if (uq.size() > 0) void'(uq.pop_front());
                else ack_viol++;
            end
            if (bus.core_hold) begin
                hold_cycles++;
                if (!prev_hold) hold_rise_ack = acks_test;
            end

            if (bus.mem_valid) begin
                bus.mem_ready = (wait_cnt >= cur_delay);
                if (!bus.mem_ready) wait_cnt++;
            end else begin
                bus.mem_ready = 1'b0;
            end
            prev_hs = bus.mem_valid && bus.mem_ready;
            if (prev_hs) begin
                writes++;
                last_hs_cyc = cyc;
                wait_cnt    = 0;
                cur_delay   = pick_delay();
                if (sb.size() == 0) begin
                    chk("unexpected_write", 64'(bus.mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    w = sb.pop_front();
                    chk("wr_addr", 64'(bus.mem_addr), 64'(w.addr));
                    chk("wr_data", 64'(bus.mem_wdata), 64'(w.data));
                    chk("wr_strb", 64'(bus.mem_wstrb), 64'hF);
                    chk("wr_align", 64'(bus.mem_addr[1:0]), 64'd0);
                end
            end

            bus.rx_ready = rx_nonempty;
            rx_nonempty  = (uq.size() != 0);
            bus.rx_data  = (uq.size() != 0) ? uq[0] : 8'h00;

            prev_ack   = bus.rx_ack;
            prev_valid = bus.mem_valid;
            prev_done  = bus.done;
            prev_err   = bus.err;
            prev_hold  = bus.core_hold;
            prev_addr  = bus.mem_addr;
            prev_wdata = bus.mem_wdata;
        end
    end

    task automatic push_frame(input frame_t f, input bit expect_writes, output int nb);
        logic [7:0]  x;
        logic [7:0]  b;
        logic [15:0] len16;
        logic [31:0] base;
        nb = 0;
        x  = 8'h00;
        for (int k = 0; k < f.prefix; k++) begin uq.push_back(pre_bytes[k]); nb++; end
        uq.push_back(8'hA5); nb++;
        for (int k = 0; k < 4; k++) begin b = f.addr[8*k +: 8]; uq.push_back(b); x ^= b; nb++; end
        len16 = 16'(f.nwords);
        for (int k = 0; k < 2; k++) begin b = len16[8*k +: 8]; uq.push_back(b); x ^= b; nb++; end
        base = {f.addr[31:2], 2'b00};
        for (int j = 0; j < f.nwords; j++) begin
            if (expect_writes) sb.push_back('{addr: base + 32'(4*j), data: f.w[j]});
            for (int k = 0; k < 4; k++) begin b = f.w[j][8*k +: 8]; uq.push_back(b); x ^= b; nb++; end
        end
`ifdef UART_LOADER_CSUM_EN
        uq.push_back(x ^ {7'd0, f.bad_csum}); nb++;
`endif
    endtask

    task automatic run_frame(input int i);
        int nb;
        bit ended;
        done_cnt = 0; err_cnt = 0; acks_test = 0; hold_rise_ack = -1; hold_cycles = 0;
        cfg_delay = tbl[i].delay;
        cur_delay = pick_delay();
        @(posedge clk); #1;
        chk($sformatf("f%0d_hold_before", i), 64'(bus.core_hold), 64'd0);
        push_frame(tbl[i], 1'b1, nb);
        ended = 1'b0;
        for (int c = 0; c < 3000 && !ended; c++) begin
            @(negedge clk);
            if (done_cnt + err_cnt > 0) ended = 1'b1;
        end
        chk($sformatf("f%0d_frame_end", i), 64'(ended), 64'd1);
        repeat (4) @(negedge clk);
        #1;
        chk($sformatf("f%0d_done_count", i), 64'(done_cnt), 64'(tbl[i].exp_done));
        chk($sformatf("f%0d_err_count", i), 64'(err_cnt), 64'(tbl[i].exp_err));
        chk($sformatf("f%0d_acks", i), 64'(acks_test), 64'(nb));
        chk($sformatf("f%0d_hold_rise", i), 64'(hold_rise_ack), 64'(tbl[i].prefix + 1));
        chk($sformatf("f%0d_hold_seen", i), 64'(hold_cycles > 0), 64'd1);
        chk($sformatf("f%0d_hold_after", i), 64'(bus.core_hold), 64'd0);
        chk($sformatf("f%0d_writes_left", i), 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int  nb;
        int  wb;
        bit  ended;
        bus.rx_data   = 8'h00;
        bus.rx_ready  = 1'b0;
        bus.mem_ready = 1'b0;
        pre_bytes = '{8'h00, 8'hFF, 8'h5A};

        tbl[0] = mk(0, 32'h0000_0100, 2, 32'h1122_3344, 32'h5566_7788, 32'h0, 32'h0, 0, 1'b0);
        tbl[1] = mk(3, 32'h0000_0100, 2, 32'h1122_3344, 32'h5566_7788, 32'h0, 32'h0, 0, 1'b0);
        tbl[2] = mk(0, 32'h0000_0010, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1'b0);
        tbl[3] = mk(0, 32'h0000_0100, 2, 32'h1122_3344, 32'h5566_7788, 32'h0, 32'h0, 5, 1'b0);
        tbl[4] = mk(0, 32'hFFFF_FFFE, 2, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h0, 32'h0, 1, 1'b0);
        tbl[5] = mk(0, 32'h0000_2000, 1, 32'hA5A5_A5A5, 32'h0, 32'h0, 32'h0, 0, 1'b0);
        tbl[6] = mk(0, 32'h0000_3001, 4, 32'hA500_00A5, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C, -1, 1'b0);
        tbl[7] = mk(0, 32'h0000_0100, 2, 32'h1122_3344, 32'h5566_7788, 32'h0, 32'h0, 0, 1'b1);

        repeat (3) @(negedge clk);
        #1;
        chk("reset_ctrl", 64'({bus.rx_ack, bus.mem_valid, bus.mem_wstrb, bus.core_hold, bus.done, bus.err}), 64'd0);
        chk("reset_addr", 64'(bus.mem_addr), 64'd0);
        chk("reset_wdata", 64'(bus.mem_wdata), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_frame(i);

        // Abort frame 0 with reset while its second data byte is being consumed.
        acks_test = 0;
        cfg_delay = 0;
        cur_delay = 0;
        @(posedge clk); #1;
        push_frame(tbl[0], 1'b0, nb);
        wb    = writes;
        ended = 1'b0;
        for (int c = 0; c < 2000 && !ended; c++) begin
            @(negedge clk);
            if (acks_test >= 9) ended = 1'b1;
        end
        chk("abort_reached_data2", 64'(ended), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_ctrl", 64'({bus.rx_ack, bus.mem_valid, bus.mem_wstrb, bus.core_hold, bus.done, bus.err}), 64'd0);
        chk("abort_addr", 64'(bus.mem_addr), 64'd0);
        chk("abort_wdata", 64'(bus.mem_wdata), 64'd0);
        chk("abort_no_write", 64'(writes - wb), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_frame(0);

        chk("ack_pulse_spacing", 64'(ack_viol), 64'd0);
        chk("no_ack_during_write", 64'(write_ack_viol), 64'd0);
        chk("write_hold_stable", 64'(hold_viol), 64'd0);
        chk("done_err_pulse_width", 64'(pulse_viol), 64'd0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
